// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI driver between NUM_REQ requesters.
// Latches the winner's command, runs the driver handshake with a timeout, returns the response.
module spi_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SPI_MAXLEN     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LENW           = $clog2(SPI_MAXLEN) + 1
) (
  input  logic                           clk,
  input  logic                           areset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LENW-1:0]        req_len,
  input  logic [NUM_REQ*SPI_MAXLEN-1:0]  req_tx,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [SPI_MAXLEN-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  input  logic                           drv_rdy,
  input  logic                           drv_done,
  input  logic [SPI_MAXLEN-1:0]          drv_rx_data,
  output logic                           drv_start,
  output logic [LENW-1:0]                drv_n_clks,
  output logic [SPI_MAXLEN-1:0]          drv_tx_data
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TOW  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic [IDXW-1:0]         win_q, win_d;
  logic [LENW-1:0]         len_q, len_d;
  logic [SPI_MAXLEN-1:0]   tx_q, tx_d;
  logic [TOW-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [SPI_MAXLEN-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    drv_start_q, drv_start_d;

  logic                    arb_found;
  logic [IDXW-1:0]         arb_idx;
  logic [LENW-1:0]         len_sel;
  logic [SPI_MAXLEN-1:0]   tx_sel;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Search starts just above the last served requester and wraps around.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] c;
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = 0;
    c         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      c = IDXW'(cand);
      if (!arb_found && req[c]) begin
        arb_found = 1'b1;
        arb_idx   = c;
      end
    end
  end

  assign len_sel = req_len[int'(arb_idx)*LENW +: LENW];
  assign tx_sel  = req_tx[int'(arb_idx)*SPI_MAXLEN +: SPI_MAXLEN];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    len_d       = len_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    drv_start_d = drv_start_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found && drv_rdy) begin
          win_d = arb_idx;
          len_d = len_sel;
          tx_d  = tx_sel;
          gnt_d = onehot(arb_idx);
          if (len_sel == '0 || len_sel > LENW'(SPI_MAXLEN)) begin
            state_d = S_ERR;
          end else begin
            state_d     = S_START;
            drv_start_d = 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A done pulse on the final timeout cycle still counts as success.
        if (drv_done) begin
          rsp_data_d  = drv_rx_data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = onehot(win_q);
          drv_start_d = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = onehot(win_q);
          drv_start_d = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + TOW'(1);
        end
      end
      S_ERR: begin
        rsp_data_d  = '0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = onehot(win_q);
        state_d     = S_RESP;
      end
      S_RESP: begin
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        drv_start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDXW'(NUM_REQ - 1);
      win_q       <= '0;
      len_q       <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      drv_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      len_q       <= len_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      drv_start_q <= drv_start_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign drv_start   = drv_start_q;
  assign drv_n_clks  = len_q;
  assign drv_tx_data = tx_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: table-driven transfers, hand sequences for corner cases,
// and randomized traffic checked by a transaction-level round-robin model.
module tb_spi_xfer_arbiter;

  localparam int N  = 4;
  localparam int ML = 16;
  localparam int TO = 16;
  localparam int LW = 5;

  logic            clk = 1'b0;
  logic            areset;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*ML-1:0] req_tx;
  logic [N-1:0]    gnt, rsp_valid;
  logic [ML-1:0]   rsp_data;
  logic            rsp_err, busy;
  logic            drv_rdy, drv_done;
  logic [ML-1:0]   drv_rx_data;
  logic            drv_start;
  logic [LW-1:0]   drv_n_clks;
  logic [ML-1:0]   drv_tx_data;

  spi_xfer_arbiter #(.NUM_REQ(N), .SPI_MAXLEN(ML), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .areset(areset), .req(req), .req_len(req_len), .req_tx(req_tx),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .drv_rdy(drv_rdy), .drv_done(drv_done), .drv_rx_data(drv_rx_data),
    .drv_start(drv_start), .drv_n_clks(drv_n_clks), .drv_tx_data(drv_tx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          m_ptr = N - 1;
  bit          inflight = 0;
  int          exp_idx = 0;
  logic [LW-1:0] exp_len = '0;
  logic [ML-1:0] exp_tx = '0;
  bit          exp_err = 0;
  logic [ML-1:0] exp_data = '0;
  int          exp_start = 0;
  int          start_hi = 0;
  int          n_high = 0;
  int          cur_delay = 0;
  logic [ML-1:0] cur_rx = '0;
  bit          rand_mode = 0;
  bit          hold_req = 0;
  bit          cond_prev = 0;
  int          miss_run = 0;
  int          resp_count = 0;
  int          busy_low = 0;
  int          grant_log[$];
  int          gap_log[$];
  logic [ML-1:0] last_data;
  logic        last_err;
  int          last_start;

  typedef struct {
    int          idx;
    int          len;
    logic [15:0] tx;
    int          delay;
    logic [15:0] rx;
    bit          err;
    logic [15:0] data;
    int          start;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cond_prev && gnt == '0) miss_run++;
    else miss_run = 0;
    if (miss_run == 3) begin
      checks++;
      failures++;
      $display("FAIL grant_stall actual=no grant expected=grant while idle with req and drv_rdy");
    end

    if (gnt != '0) begin
      int w, a;
      w = -1;
      a = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req[c]) w = c;
      end
      for (int k = N - 1; k >= 0; k--) if (gnt[k]) a = k;
      chk("gnt_onehot", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
      chk("gnt_drv_rdy", 32'(drv_rdy), 32'd1);
      chk("gnt_not_inflight", 32'(inflight), 32'd0);
      grant_log.push_back(a);
      inflight = 1;
      exp_idx  = a;
      exp_len  = req_len[a*LW +: LW];
      exp_tx   = req_tx[a*ML +: ML];
      if (rand_mode) begin
        cur_delay = $urandom_range(1, 18);
        cur_rx    = ML'($urandom);
      end
      if (exp_len == 0 || exp_len > ML) begin
        exp_err = 1; exp_data = '0; exp_start = 0;
      end else if (cur_delay >= 1 && cur_delay <= TO) begin
        exp_err = 0; exp_data = cur_rx; exp_start = cur_delay + 1;
      end else begin
        exp_err = 1; exp_data = '0; exp_start = TO + 1;
      end
      if (!hold_req) req[a] = 1'b0;
    end

    if (drv_start) begin
      start_hi++;
      chk("drv_n_clks", 32'(drv_n_clks), 32'(exp_len));
      chk("drv_tx_data", 32'(drv_tx_data), 32'(exp_tx));
    end

    if (!busy) busy_low++;
    else begin
      if (busy_low > 0) gap_log.push_back(busy_low);
      busy_low = 0;
    end

    if (rsp_valid != '0) begin
      chk("rsp_expected", 32'(inflight), 32'd1);
      chk("rsp_valid", 32'(rsp_valid), 32'd1 << exp_idx);
      chk("rsp_data", 32'(rsp_data), 32'(exp_data));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("start_cycles", start_hi, exp_start);
      last_data  = rsp_data;
      last_err   = rsp_err;
      last_start = start_hi;
      m_ptr      = exp_idx;
      inflight   = 0;
      start_hi   = 0;
      resp_count++;
    end

    // driver model: done on WAIT cycle cur_delay, stray done pulses while idle
    if (drv_start) n_high++;
    else n_high = 0;
    drv_done = drv_start && cur_delay > 0 && n_high == cur_delay + 1;
    if (!drv_start && rand_mode && $urandom_range(0, 3) == 0) drv_done = 1'b1;
    drv_rx_data = (drv_done && drv_start) ? cur_rx : ML'($urandom);

    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_len[i*LW +: LW] = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 31))
                                                               : LW'($urandom_range(1, 16));
            req_tx[i*ML +: ML]  = ML'($urandom);
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
      drv_rdy = ($urandom_range(0, 3) != 0);
    end
    cond_prev = !inflight && (req != '0) && drv_rdy && !areset;
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    int b;
    b = 0;
    while (resp_count < target && b < budget) begin
      tick();
      b++;
    end
    if (resp_count < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d responses expected=%0d", name, resp_count, target);
    end
  endtask

  task automatic set_cmd(input int i, input int len, input logic [15:0] tx);
    req_len[i*LW +: LW] = LW'(len);
    req_tx[i*ML +: ML]  = tx;
  endtask

  initial begin
    int r0, b;
    vt[0] = '{2,  8, 16'h00A5, 10, 16'h005A, 0, 16'h005A, 11};
    vt[1] = '{3, 16, 16'hFFFF,  0, 16'h1111, 1, 16'h0000, 17};
    vt[2] = '{0,  1, 16'h0001, 16, 16'hBEEF, 0, 16'hBEEF, 17};
    vt[3] = '{3, 16, 16'h8000,  1, 16'h8001, 0, 16'h8001,  2};
    vt[4] = '{1,  5, 16'h001F, 17, 16'h2222, 1, 16'h0000, 17};
    vt[5] = '{0, 31, 16'h3333,  3, 16'h4444, 1, 16'h0000,  0};
    vt[6] = '{1,  0, 16'h1234,  3, 16'h5555, 1, 16'h0000,  0};
    vt[7] = '{1, 17, 16'h4321,  3, 16'h6666, 1, 16'h0000,  0};

    areset = 1'b1;
    req = '0; req_len = '0; req_tx = '0;
    drv_rdy = 1'b1; drv_done = 1'b0; drv_rx_data = '0;
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drv_start", 32'(drv_start), 0);
    chk("rst_drv_n_clks", 32'(drv_n_clks), 0);
    chk("rst_drv_tx_data", 32'(drv_tx_data), 0);
    tick();
    areset = 1'b0;
    tick();

    // fairness: all requests held high
    for (int i = 0; i < N; i++) set_cmd(i, 4, 16'(16'h0100 + i));
    cur_delay = 3; cur_rx = 16'h0C3C;
    grant_log.delete(); gap_log.delete(); busy_low = 0;
    hold_req = 1; req = '1;
    wait_resp(resp_count + 5, 150, "fair");
    req = '0; hold_req = 0;
    chk("fair_count", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      chk($sformatf("fair_order_%0d", k), grant_log[k], k % N);
    chk("fair_gaps", gap_log.size(), 4);
    foreach (gap_log[k]) chk($sformatf("fair_gap_%0d", k), gap_log[k], 1);

    // single-requester transfers from the table
    for (int v = 0; v < 8; v++) begin
      set_cmd(vt[v].idx, vt[v].len, vt[v].tx);
      cur_delay = vt[v].delay; cur_rx = vt[v].rx;
      r0 = resp_count;
      req[vt[v].idx] = 1'b1;
      wait_resp(r0 + 1, 60, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_data", v), 32'(last_data), 32'(vt[v].data));
      chk($sformatf("vec%0d_err", v), 32'(last_err), 32'(vt[v].err));
      chk($sformatf("vec%0d_start", v), last_start, vt[v].start);
    end

    // last error served requester 1, so requester 2 beats requester 0
    set_cmd(0, 4, 16'h0A0A); set_cmd(2, 4, 16'h0B0B);
    cur_delay = 2; cur_rx = 16'h7777;
    grant_log.delete();
    req[0] = 1'b1; req[2] = 1'b1;
    wait_resp(resp_count + 2, 60, "ptr");
    chk("ptr_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("ptr_first", grant_log[0], 2);
      chk("ptr_second", grant_log[1], 0);
    end

    // asynchronous reset while waiting on the driver
    set_cmd(2, 8, 16'h00C3);
    cur_delay = 0;
    req[2] = 1'b1;
    b = 0;
    while (start_hi < 4 && b < 30) begin tick(); b++; end
    chk("rst_mid_reached_wait", 32'(start_hi >= 4), 1);
    #2 areset = 1'b1;
    #1;
    chk("rst_mid_drv_start", 32'(drv_start), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_gnt", 32'(gnt), 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    inflight = 0; m_ptr = N - 1; start_hi = 0; req = '0;
    repeat (3) tick();
    areset = 1'b0;
    for (int i = 0; i < N; i++) set_cmd(i, 4, 16'(16'h0200 + i));
    cur_delay = 2; cur_rx = 16'h1357;
    grant_log.delete();
    req = '1;
    wait_resp(resp_count + 4, 80, "post_rst");
    chk("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // randomized traffic against the model
    r0 = resp_count;
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    req = '0; drv_rdy = 1'b1;
    repeat (3) tick();
    b = 0;
    while (inflight && b < 100) begin tick(); b++; end
    chk("rand_drained", 32'(inflight), 0);
    chk("rand_progress", 32'((resp_count - r0) > 30), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Round-robin scheduler that shares one spi_drv instance between NUM_REQ independent requesters. It accepts a transfer command (length and transmit word) from each requester. It grants one requester at a time and sequences the driver's start/ready handshake. It then returns the received word, or an error, to the winning requester. Sits between client logic (sensor pollers, config loaders) and the SPI driver, all in the clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SPI_MAXLEN, 16, maximum bits per transfer; must match the driver
TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT before abort
LENW, $clog2(SPI_MAXLEN)+1, derived width of length fields

Ports:
clk  in  1  system clock
areset  in  1  asynchronous reset, active-high
req  in  NUM_REQ  per-requester transfer request, level
req_len  in  NUM_REQ*LENW  packed per-requester bit count; slice i = bits [i*LENW +: LENW]
req_tx  in  NUM_REQ*SPI_MAXLEN  packed per-requester transmit words
gnt  out  NUM_REQ  one-hot, one-cycle pulse: command captured
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: response ready
rsp_data  out  SPI_MAXLEN  received word; valid with rsp_valid
rsp_err  out  1  error qualifier; valid with rsp_valid
busy  out  1  high in every state except IDLE
drv_rdy  in  1  driver ready for a new transfer
drv_done  in  1  one-cycle pulse: driver finished the transfer
drv_rx_data  in  SPI_MAXLEN  driver received word
drv_start  out  1  transfer start, held high for the whole transfer
drv_n_clks  out  LENW  latched length
drv_tx_data  out  SPI_MAXLEN  latched transmit word

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; rr pointer=NUM_REQ-1 so requester 0 wins first; timeout counter 0; latched length/data 0.
- States: IDLE, START, WAIT, RESP, ERR.
- IDLE:
  - Condition: |req && drv_rdy.
  - Arbitration: winner = first asserted req searching upward from ptr+1, wrapping modulo NUM_REQ.
  - Same edge: latch winner index, req_len slice, req_tx slice; pulse gnt[winner] for exactly the next cycle.
  - Length check: if latched len == 0 or len > SPI_MAXLEN, go ERR; otherwise go START.
  - If req is present but drv_rdy=0, stay in IDLE; no grant.
- START:
  - drv_start=1; drv_n_clks and drv_tx_data drive the latched values, stable until drv_start falls.
  - Next cycle go WAIT; clear the timeout counter.
- WAIT:
  - drv_start remains 1; counter increments every cycle.
  - On drv_done: capture drv_rx_data into rsp_data, rsp_err=0, go RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no drv_done: rsp_data=0, rsp_err=1, go RESP.
  - drv_done and timeout in the same cycle: done wins.
- drv_start drops to 0 on the cycle that enters RESP.
- ERR: rsp_data=0, rsp_err=1, go RESP. No drv_start is issued.
- RESP:
  - rsp_valid[winner]=1 for one cycle; ptr=winner; go IDLE.
  - Latency: a new grant is possible no earlier than the cycle after RESP.
- rsp_data and rsp_err hold their value until the next RESP. rsp_valid and gnt are 0 outside their pulse cycles.
- Requester may drop req any time after its gnt. A req dropped before grant is simply not serviced. A req held high after its rsp_valid is treated as a new request.
- drv_done outside WAIT is ignored.
- Mid-transfer reset: drv_start falls asynchronously; no rsp_valid is generated for the aborted transfer.
- Fairness: with all req high continuously, grant order is 0,1,...,NUM_REQ-1,0,...

Test Plan:
- Single req[2], len=8, tx=0x00A5; drv_rdy=1; driver model returns 0x005A after 10 cycles -> gnt=4'b0100 one cycle; drv_start high 11 cycles with n_clks=8, tx=0x00A5; rsp_valid=4'b0100, rsp_data=0x005A, rsp_err=0.
- All four req held high; driver done after 3 cycles each -> grant sequence 0,1,2,3,0; each rsp_valid follows its own gnt; busy low exactly one cycle between transfers.
- req[1] with len=0, then len=17 -> gnt[1] pulses; drv_start never asserts; rsp_valid[1] with rsp_err=1, rsp_data=0; pointer advances so req[2] is served next.
- TIMEOUT_CYCLES=16, driver never pulses done -> drv_start high 17 cycles (START + 16 WAIT cycles) then drops; rsp_err=1, rsp_data=0; next request proceeds normally.
- drv_done arrives in the same cycle as the timeout expiry -> rsp_err=0, rsp_data=drv_rx_data.
- areset asserted during WAIT -> drv_start, busy and gnt go to 0 without a clock edge; no rsp_valid; after release req[0] is granted first.
